// File: rtl/imem_loader.sv
// imem_loader: framed byte-stream loader for the instruction memory.
// Assembles little-endian 32-bit words from a header/payload/checksum frame,
// writes them to the instruction memory and releases the core only after a
// complete image with a matching XOR checksum has been written.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_HDR0  | waiting for word-count low byte
// S_HDR1  | waiting for word-count high byte, length check
// S_DATA  | receiving payload bytes, packing words, writing memory
// S_CSUM  | waiting for the checksum byte
// S_DONE  | image valid, core released
// S_ERROR | load aborted (length overflow or checksum mismatch)

module imem_loader #(
    parameter int n      = 32,
    parameter int ADDR_W = 8
) (
    input  logic           clk,
    input  logic           areset,
    input  logic           in_valid,
    input  logic [7:0]     in_data,
    output logic           in_ready,
    input  logic           start,
    output logic           mem_we,
    output logic [n-1:0]   mem_addr,
    output logic [n-1:0]   mem_wdata,
    output logic           cpu_hold,
    output logic           done,
    output logic           error,
    output logic [1:0]     err_code
);

    typedef enum logic [2:0] {
        S_HDR0  = 3'd0,
        S_HDR1  = 3'd1,
        S_DATA  = 3'd2,
        S_CSUM  = 3'd3,
        S_DONE  = 3'd4,
        S_ERROR = 3'd5
    } state_t;

    // Largest accepted word count; 17 bits so that ADDR_W = 16 still fits.
    localparam logic [16:0] CAPACITY = 17'(1) << ADDR_W;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_LEN  = 2'd1;
    localparam logic [1:0] ERR_CSUM = 2'd2;

    state_t         r_state;
    logic [15:0]    r_n_words;
    logic [16:0]    r_word_cnt;
    logic [1:0]     r_lane;
    logic [23:0]    r_lo_bytes;
    logic [7:0]     r_xor;
    logic           r_mem_we;
    logic [n-1:0]   r_mem_addr;
    logic [n-1:0]   r_mem_wdata;
    logic           r_cpu_hold;
    logic           r_done;
    logic           r_error;
    logic [1:0]     r_err_code;

    logic           w_xfer;
    logic [16:0]    w_n_hdr;
    logic [16:0]    w_word_next;

    // The loader never stalls mid-frame; readiness is purely the state.
    assign in_ready    = (r_state != S_DONE) && (r_state != S_ERROR);
    assign w_xfer      = in_valid & in_ready;
    assign w_n_hdr     = {1'b0, in_data, r_n_words[7:0]};
    assign w_word_next = r_word_cnt + 17'd1;

    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign cpu_hold  = r_cpu_hold;
    assign done      = r_done;
    assign error     = r_error;
    assign err_code  = r_err_code;

    // Frame sequencer: header decode, word packing, memory write and status.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            r_state     <= S_HDR0;
            r_n_words   <= 16'd0;
            r_word_cnt  <= 17'd0;
            r_lane      <= 2'd0;
            r_lo_bytes  <= 24'd0;
            r_xor       <= 8'd0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_cpu_hold  <= 1'b1;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_err_code  <= ERR_NONE;
        end else begin
            // Write enable is a single-cycle pulse per committed word.
            r_mem_we <= 1'b0;
            case (r_state)
                S_HDR0: begin
                    if (w_xfer) begin
                        r_n_words[7:0] <= in_data;
                        r_state        <= S_HDR1;
                    end
                end
                S_HDR1: begin
                    if (w_xfer) begin
                        r_n_words[15:8] <= in_data;
                        if (w_n_hdr > CAPACITY) begin
                            r_state    <= S_ERROR;
                            r_error    <= 1'b1;
                            r_err_code <= ERR_LEN;
                        end else if (w_n_hdr == 17'd0) begin
                            r_state <= S_CSUM;
                        end else begin
                            r_state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (w_xfer) begin
                        r_xor  <= r_xor ^ in_data;
                        r_lane <= r_lane + 2'd1;
                        case (r_lane)
                            2'd0: r_lo_bytes[7:0]   <= in_data;
                            2'd1: r_lo_bytes[15:8]  <= in_data;
                            2'd2: r_lo_bytes[23:16] <= in_data;
                            default: begin
                                // Lane 3 completes the word: write it next cycle.
                                r_mem_we    <= 1'b1;
                                r_mem_addr  <= n'({r_word_cnt, 2'b00});
                                r_mem_wdata <= n'({in_data, r_lo_bytes});
                                r_word_cnt  <= w_word_next;
                                if (w_word_next == {1'b0, r_n_words}) begin
                                    r_state <= S_CSUM;
                                end
                            end
                        endcase
                    end
                end
                S_CSUM: begin
                    if (w_xfer) begin
                        if (in_data == r_xor) begin
                            r_state    <= S_DONE;
                            r_done     <= 1'b1;
                            r_cpu_hold <= 1'b0;
                        end else begin
                            r_state    <= S_ERROR;
                            r_error    <= 1'b1;
                            r_err_code <= ERR_CSUM;
                        end
                    end
                end
                S_DONE, S_ERROR: begin
                    // Restart only from a terminal state; memory contents are kept.
                    if (start) begin
                        r_state    <= S_HDR0;
                        r_done     <= 1'b0;
                        r_error    <= 1'b0;
                        r_err_code <= ERR_NONE;
                        r_cpu_hold <= 1'b1;
                        r_n_words  <= 16'd0;
                        r_word_cnt <= 17'd0;
                        r_lane     <= 2'd0;
                        r_lo_bytes <= 24'd0;
                        r_xor      <= 8'd0;
                    end
                end
                default: begin
                    r_state <= S_HDR0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed and randomized frames against a frame-level model.
module tb_imem_loader;

    localparam int ADDR_W = 8;
    localparam int CAP    = 1 << ADDR_W;

    logic        clk;
    logic        areset;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        start;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;
    logic [1:0]  err_code;

    imem_loader #(.n(32), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .areset    (areset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .start     (start),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .error     (error),
        .err_code  (err_code)
    );

    int total  = 0;
    int passed = 0;
    int we_count = 0;
    logic [31:0] last_addr = 0;
    logic [31:0] last_data = 0;
    logic [7:0]  fr[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every write pulse the memory would see.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            we_count++;
            last_addr = mem_addr;
            last_data = mem_wdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    task automatic idle(input int c, input bit noise);
        repeat (c) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            start    = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, ":in_ready"}, in_ready, 1);
        chk({tag, ":mem_we"},   mem_we, 0);
        chk({tag, ":mem_addr"}, mem_addr, 0);
        chk({tag, ":mem_wdata"}, mem_wdata, 0);
        chk({tag, ":status"}, {cpu_hold, done, error, err_code}, 5'b10000);
    endtask

    task automatic do_start(input string tag);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, ":start_ready"},  in_ready, 1);
        chk({tag, ":start_status"}, {cpu_hold, done, error, err_code}, 5'b10000);
    endtask

    task automatic build_frame(input int nw, input bit good);
        logic [7:0] x;
        logic [7:0] b;
        x = 8'h00;
        fr.delete();
        fr.push_back(nw[7:0]);
        fr.push_back(nw[15:8]);
        if (nw <= CAP) begin
            for (int i = 0; i < 4 * nw; i++) begin
                b = 8'($urandom);
                x = x ^ b;
                fr.push_back(b);
            end
            fr.push_back(good ? x : (x ^ 8'($urandom_range(1, 255))));
        end
    endtask

    // Sends fr and checks every byte against what the frame rules predict.
    task automatic run_frame(input string tag, input int gap, input bit noise);
        int nw;
        int consumed;
        int first_we;
        int k;
        bit len_bad;
        bit exp_we;
        logic [7:0] x;
        logic [31:0] w;
        logic [4:0] exp_status;
        nw       = int'(fr[0]) + 256 * int'(fr[1]);
        len_bad  = (nw > CAP);
        consumed = len_bad ? 2 : 4 * nw + 3;
        x = 8'h00;
        if (!len_bad) begin
            for (int i = 0; i < 4 * nw; i++) x = x ^ fr[2 + i];
        end
        first_we = we_count;
        for (int i = 0; i < consumed; i++) begin
            if (i > 0 && gap > 0) idle($urandom_range(0, gap), noise);
            chk({tag, ":in_ready"}, in_ready, 1);
            send_byte(fr[i]);
            exp_we = !len_bad && (i >= 2) && (i < 2 + 4 * nw) && ((i - 2) % 4 == 3);
            chk({tag, ":mem_we"}, mem_we, exp_we);
            if (exp_we) begin
                k = (i - 2) / 4;
                w = {fr[i], fr[i - 1], fr[i - 2], fr[i - 3]};
                chk({tag, ":mem_addr"},  mem_addr, 32'(4 * k));
                chk({tag, ":mem_wdata"}, mem_wdata, w);
            end
            if (i < consumed - 1) begin
                chk({tag, ":busy_status"}, {done, error, cpu_hold}, 3'b001);
            end
        end
        if (len_bad)                   exp_status = 5'b10101;
        else if (fr[consumed - 1] == x) exp_status = 5'b01000;
        else                           exp_status = 5'b10110;
        chk({tag, ":final_status"}, {cpu_hold, done, error, err_code}, exp_status);
        chk({tag, ":final_ready"}, in_ready, 0);
        idle(2, 1'b0);
        chk({tag, ":write_count"}, we_count - first_we, len_bad ? 0 : nw);
    endtask

    task automatic load_frame1;
        fr = {8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00,
              8'h93, 8'h05, 8'h20, 8'h00, 8'hB0};
    endtask

    initial begin
        int nw;
        int r;
        in_valid = 1'b0;
        in_data  = 8'h00;
        start    = 1'b0;
        areset   = 1'b1;
        #1 areset = 1'b0;
        #11;
        check_reset_values("reset");
        @(negedge clk) areset = 1'b1;
        @(posedge clk); #1;

        // Basic two-word image.
        load_frame1();
        run_frame("t1", 0, 1'b0);
        chk("t1:last_addr", last_addr, 32'h4);
        chk("t1:last_data", last_data, 32'h00200593);

        // Bytes offered while DONE are not accepted.
        r = we_count;
        repeat (4) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            @(posedge clk); #1;
            chk("done_hold:ready", in_ready, 0);
            chk("done_hold:status", {cpu_hold, done, error, err_code}, 5'b01000);
        end
        in_valid = 1'b0;
        idle(1, 1'b0);
        chk("done_hold:writes", we_count - r, 0);

        // Bad checksum, then restart and reload.
        do_start("t2");
        load_frame1();
        fr[10] = 8'hB1;
        run_frame("t2", 0, 1'b0);
        do_start("t2r");
        load_frame1();
        run_frame("t2r", 0, 1'b0);

        // Empty image.
        do_start("t3");
        fr = {8'h00, 8'h00, 8'h00};
        run_frame("t3", 0, 1'b0);

        // Length one past capacity.
        do_start("t4");
        fr = {8'h01, 8'h01};
        run_frame("t4", 0, 1'b0);

        // Frame 1 with idle gaps and ignored start pulses.
        do_start("t5");
        load_frame1();
        run_frame("t5", 5, 1'b1);

        // Randomized frames.
        for (int it = 0; it < 12; it++) begin
            do_start("rnd");
            r = $urandom_range(0, 9);
            if (r == 0)      nw = 0;
            else if (r == 1) nw = $urandom_range(CAP + 1, 65535);
            else             nw = $urandom_range(1, 12);
            build_frame(nw, 1'($urandom_range(0, 3) != 0));
            run_frame("rnd", $urandom_range(0, 3), 1'b1);
        end

        // Full-capacity image.
        do_start("full");
        build_frame(CAP, 1'b1);
        run_frame("full", 0, 1'b0);
        chk("full:last_addr", last_addr, 32'(4 * (CAP - 1)));

        // Asynchronous reset in the middle of a payload.
        do_start("t6");
        load_frame1();
        for (int i = 0; i < 8; i++) send_byte(fr[i]);
        #2 areset = 1'b0;
        #1;
        check_reset_values("t6_reset");
        repeat (2) @(posedge clk);
        @(negedge clk) areset = 1'b1;
        @(posedge clk); #1;
        run_frame("t6", 0, 1'b0);
        chk("t6:last_addr", last_addr, 32'h4);
        chk("t6:last_data", last_data, 32'h00200593);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
